// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundle of the two requester ports (CPU = port 0,
// DMA = port 1) and the shared memory command/response port.
//   slave  : arbiter side (takes requests and mem_dout, drives grants,
//            read returns and the memory command)
//   master : requester/memory side (the mirror image)
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req0, req1;
    logic          lock0, lock1;
    logic          we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [2:0]    op0, op1;
    logic          gnt0, gnt1;
    logic          rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [2:0]    mem_op;
    logic          mem_we, mem_re;
    logic [DW-1:0] mem_dout;

    modport slave (
        input  req0, req1, lock0, lock1, we0, we1, addr0, addr1,
               wdata0, wdata1, op0, op1, mem_dout,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               mem_addr, mem_din, mem_op, mem_we, mem_re
    );

    modport master (
        output req0, req1, lock0, lock1, we0, we1, addr0, addr1,
               wdata0, wdata1, op0, op1, mem_dout,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               mem_addr, mem_din, mem_op, mem_we, mem_re
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (CPU/DMA) data memory arbiter with locked bursts.
// Ports:
//   clock  - single clock, all state on posedge
//   reset  - asynchronous, active-high
//   bus    - dmem_arbiter_if.slave: requests, grants, read returns and the
//            memory command (mem_*) / read data (mem_dout)
// Grants are combinational from the current requests and the arbiter
// state. A locked owner keeps the memory until it drops lock or req, or
// until it has used MAX_BURST beats while the other port is waiting.
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 8
) (
    input  logic           clock,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [7:0] MAX_B = 8'(MAX_BURST);

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;
    logic          g0, g1, gnt0, gnt1, limit;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din;
    logic [2:0]    m_op;
    logic          m_we, m_re;

    always_comb begin
        g0      = 1'b0;
        g1      = 1'b0;
        limit   = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                // Contention goes to the port that was not granted last.
                if (bus.req0 && (!bus.req1 || last_q)) g0 = 1'b1;
                else if (bus.req1)                      g1 = 1'b1;
                if (g0 && bus.lock0) begin
                    state_d = OWN0;
                    cnt_d   = 8'd1;
                end else if (g1 && bus.lock1) begin
                    state_d = OWN1;
                    cnt_d   = 8'd1;
                end
            end
            OWN0: begin
                // Once the burst budget is spent, a waiting peer forces a
                // release; >= so a burst that ran long while the peer was
                // idle still yields as soon as the peer shows up.
                limit = (cnt_q >= MAX_B) && bus.req1;
                g0    = bus.req0 && !limit;
                if (g0 && bus.lock0) begin
                    cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                end else begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end
            end
            OWN1: begin
                limit = (cnt_q >= MAX_B) && bus.req0;
                g1    = bus.req1 && !limit;
                if (g1 && bus.lock1) begin
                    cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                end else begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // No beat may leave while reset is held, even though requests may be up.
    assign gnt0 = g0 && !reset;
    assign gnt1 = g1 && !reset;

    always_comb begin
        last_d    = last_q;
        if (gnt0) last_d = 1'b0;
        if (gnt1) last_d = 1'b1;
        rvalid0_d = gnt0 && !bus.we0;
        rvalid1_d = gnt1 && !bus.we1;
    end

    always_comb begin
        m_addr = '0;
        m_din  = '0;
        m_op   = '0;
        m_we   = 1'b0;
        m_re   = 1'b0;
        if (gnt0) begin
            m_addr = bus.addr0;
            m_din  = bus.wdata0;
            m_op   = bus.op0;
            m_we   = bus.we0;
            m_re   = !bus.we0;
        end else if (gnt1) begin
            m_addr = bus.addr1;
            m_din  = bus.wdata1;
            m_op   = bus.op1;
            m_we   = bus.we1;
            m_re   = !bus.we1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            cnt_q     <= 8'd0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    assign bus.gnt0     = gnt0;
    assign bus.gnt1     = gnt1;
    assign bus.mem_addr = m_addr;
    assign bus.mem_din  = m_din;
    assign bus.mem_op   = m_op;
    assign bus.mem_we   = m_we;
    assign bus.mem_re   = m_re;
    // Memory returns read data the cycle after mem_re; steer it to the
    // port that issued that read.
    assign bus.rvalid0  = rvalid0_q;
    assign bus.rvalid1  = rvalid1_q;
    assign bus.rdata0   = rvalid0_q ? bus.mem_dout : '0;
    assign bus.rdata1   = rvalid1_q ? bus.mem_dout : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a behavioural model.
module tb_dmem_arbiter;
    localparam int MAXB = 8;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

    dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(MAXB)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_own   = -1;   // port holding a locked burst, -1 when free
    int m_beats = 0;    // beats granted in the current burst
    bit m_last  = 1'b1; // port granted most recently
    bit m_rv0   = 1'b0; // read issued last cycle by port 0
    bit m_rv1   = 1'b0;

    always @(negedge clock) begin : cmp
        int sel;
        logic [1:0] r, l, w;
        logic [31:0] ea, ed;
        logic [2:0] eo;
        r = {bus.req1, bus.req0};
        l = {bus.lock1, bus.lock0};
        w = {bus.we1, bus.we0};
        sel = -1;
        if (!reset) begin
            if (m_own < 0) begin
                if (r[0] && r[1]) sel = m_last ? 0 : 1;
                else if (r[0])    sel = 0;
                else if (r[1])    sel = 1;
            end else if (r[m_own] && !(m_beats >= MAXB && r[1-m_own])) begin
                sel = m_own;
            end
        end
        ea = (sel == 0) ? bus.addr0  : (sel == 1) ? bus.addr1  : 32'd0;
        ed = (sel == 0) ? bus.wdata0 : (sel == 1) ? bus.wdata1 : 32'd0;
        eo = (sel == 0) ? bus.op0    : (sel == 1) ? bus.op1    : 3'd0;
        chk("m_gnt0", bus.gnt0, sel == 0);
        chk("m_gnt1", bus.gnt1, sel == 1);
        chk("m_mem_we", bus.mem_we, sel >= 0 && w[sel]);
        chk("m_mem_re", bus.mem_re, sel >= 0 && !w[sel]);
        chk("m_mem_addr", bus.mem_addr, ea);
        chk("m_mem_din", bus.mem_din, ed);
        chk("m_mem_op", bus.mem_op, eo);
        chk("m_rvalid0", bus.rvalid0, !reset && m_rv0);
        chk("m_rvalid1", bus.rvalid1, !reset && m_rv1);
        chk("m_rdata0", bus.rdata0, (!reset && m_rv0) ? bus.mem_dout : 32'd0);
        chk("m_rdata1", bus.rdata1, (!reset && m_rv1) ? bus.mem_dout : 32'd0);
        if (reset) begin
            m_own = -1; m_beats = 0; m_last = 1'b1; m_rv0 = 1'b0; m_rv1 = 1'b0;
        end else begin
            m_rv0 = (sel == 0) && !w[0];
            m_rv1 = (sel == 1) && !w[1];
            if (sel >= 0) m_last = (sel == 1);
            if (m_own < 0) begin
                if (sel >= 0 && l[sel]) begin m_own = sel; m_beats = 1; end
            end else if (sel < 0 || !l[sel]) begin
                m_own = -1; m_beats = 0;
            end else if (m_beats < 255) begin
                m_beats++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
        bus.mem_dout = $urandom;
        bus.addr0 = $urandom; bus.addr1 = $urandom;
        bus.wdata0 = $urandom; bus.wdata1 = $urandom;
        bus.op0 = 3'($urandom); bus.op1 = 3'($urandom);
    endtask

    task automatic drv(input bit p, input bit rq, input bit lk, input bit wr);
        if (!p) begin bus.req0 = rq; bus.lock0 = lk; bus.we0 = wr; end
        else    begin bus.req1 = rq; bus.lock1 = lk; bus.we1 = wr; end
    endtask

    task automatic idle();
        drv(0, 0, 0, 0);
        drv(1, 0, 0, 0);
    endtask

    initial begin
        int b1, first0, run, mode;
        int seq[$];
        reset = 1'b1;
        bus.mem_dout = '0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        bus.op0 = '0; bus.op1 = '0;
        drv(0, 1, 0, 0);
        drv(1, 1, 0, 0);

        // Reset with both ports requesting: nothing leaves.
        step(); #2;
        chk("rst_gnt0", bus.gnt0, 0);
        chk("rst_gnt1", bus.gnt1, 0);
        chk("rst_mem_re", bus.mem_re, 0);

        // Both reading, no lock: 0 first, then alternate.
        step(); reset = 1'b0; #2;
        chk("alt_c1_gnt0", bus.gnt0, 1);
        chk("alt_c1_gnt1", bus.gnt1, 0);
        step(); #2;
        chk("alt_c2_gnt1", bus.gnt1, 1);
        chk("alt_c2_rvalid0", bus.rvalid0, 1);
        chk("alt_c2_rdata0", bus.rdata0, bus.mem_dout);
        step(); #2;
        chk("alt_c3_gnt0", bus.gnt0, 1);
        chk("alt_c3_rvalid1", bus.rvalid1, 1);
        step(); idle();

        // Single write from port 0.
        step();
        drv(0, 1, 0, 1);
        bus.addr0 = 32'h10; bus.wdata0 = 32'hDEADBEEF;
        #2;
        chk("wr_gnt0", bus.gnt0, 1);
        chk("wr_mem_we", bus.mem_we, 1);
        chk("wr_mem_re", bus.mem_re, 0);
        chk("wr_mem_addr", bus.mem_addr, 32'h10);
        chk("wr_mem_din", bus.mem_din, 32'hDEADBEEF);
        step(); idle(); #2;
        chk("wr_no_rvalid0", bus.rvalid0, 0);

        // Port 1 locked burst of 12, port 0 joins from beat 3.
        step();
        b1 = 0; first0 = -1;
        for (int c = 0; c < 60 && b1 < 12; c++) begin
            step();
            drv(1, b1 < 12, b1 < 11, 0);
            drv(0, b1 >= 2, 0, 0);
            #2;
            seq.push_back(bus.gnt0 ? 0 : bus.gnt1 ? 1 : 2);
            if (bus.gnt1) b1++;
            if (bus.gnt0 && first0 < 0) first0 = seq.size() - 1;
            if (first0 < 0 && bus.gnt1) run = b1;
        end
        chk("brst_done", b1, 12);
        chk("brst_run_before_gnt0", run, MAXB);
        if (first0 > 0 && first0 + 1 < seq.size()) begin
            chk("brst_bubble", seq[first0-1], 2);
            chk("brst_then_gnt1", seq[first0+1], 1);
        end else begin
            chk("brst_gnt0_seen", 0, 1);
        end
        step(); idle();
        step();

        // Port 1 locked burst of 12 alone: never cut.
        run = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            drv(1, 1, i < 11, 0);
            #2;
            if (bus.gnt1) run++;
        end
        chk("solo_run", run, 12);
        step();
        drv(0, 1, 0, 0);
        drv(1, 1, 0, 0);
        #2;
        chk("solo_exit_gnt0", bus.gnt0, 1);
        step(); idle();
        step();

        // Reset on beat 4 of a locked read burst.
        for (int i = 0; i < 3; i++) begin
            step();
            drv(1, 1, 1, 0);
        end
        step();
        reset = 1'b1;
        #2;
        chk("mid_rst_gnt1", bus.gnt1, 0);
        chk("mid_rst_rvalid1", bus.rvalid1, 0);
        chk("mid_rst_mem_re", bus.mem_re, 0);
        step();
        step();
        reset = 1'b0;
        drv(0, 1, 0, 0);
        drv(1, 1, 0, 0);
        #2;
        chk("post_rst_gnt0", bus.gnt0, 1);
        step(); idle();
        step();

        // Owner 0 drops req for a cycle while port 1 waits.
        step();
        drv(0, 1, 1, 0);
        #2;
        chk("own0_a_gnt0", bus.gnt0, 1);
        step();
        drv(1, 1, 0, 0);
        #2;
        chk("own0_b_gnt0", bus.gnt0, 1);
        chk("own0_b_gnt1", bus.gnt1, 0);
        step();
        drv(0, 0, 0, 0);
        #2;
        chk("own0_c_gnt0", bus.gnt0, 0);
        chk("own0_c_gnt1", bus.gnt1, 0);
        step();
        #2;
        chk("own0_d_gnt1", bus.gnt1, 1);
        step(); idle();

        // Randomized traffic; mode shifts the load between ports.
        mode = 0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (i % 60 == 0) mode = $urandom_range(0, 2);
            reset = ($urandom_range(0, 299) == 0);
            drv(0, (mode == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0),
                $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            drv(1, (mode == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0),
                $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
        end
        step();
        reset = 1'b0;
        idle();
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
